// File: rtl/control_pipe_if.sv
// Control-pipe bundle: ID-stage decode inputs plus the staged
// EX/MEM/WB control outputs of the pipelined CPU.
interface control_pipe_if #(
  parameter int REG_W   = 4,
  parameter int FUNCT_W = 4
);
  logic               id_valid;
  logic [3:0]         id_opcode;
  logic [FUNCT_W-1:0] id_funct;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic               ex_branch_taken;
  logic               stall;
  logic               ex_alusrc;
  logic [1:0]         ex_aluop;
  logic               ex_branch;
  logic               ex_jump;
  logic               mem_memread;
  logic               mem_memwrite;
  logic               wb_memtoreg;
  logic               wb_regwrite;
  logic               wb_r15;
  logic [REG_W-1:0]   wb_rd;
  logic               halted;

  modport master (
    output id_valid, id_opcode, id_funct,
    output id_rs, id_rt, id_rd, ex_branch_taken,
    input  stall, ex_alusrc, ex_aluop,
    input  ex_branch, ex_jump,
    input  mem_memread, mem_memwrite,
    input  wb_memtoreg, wb_regwrite, wb_r15,
    input  wb_rd, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_funct,
    input  id_rs, id_rt, id_rd, ex_branch_taken,
    output stall, ex_alusrc, ex_aluop,
    output ex_branch, ex_jump,
    output mem_memread, mem_memwrite,
    output wb_memtoreg, wb_regwrite, wb_r15,
    output wb_rd, halted
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, load-use stall, branch flush and sticky HALT.
module control_pipe #(
  parameter int               REG_W   = 4,
  parameter int               FUNCT_W = 4,
  parameter logic [FUNCT_W-1:0] MUL_FN = 4'b0100,
  parameter logic [FUNCT_W-1:0] DIV_FN = 4'b0101,
  parameter bit               HAZ_EN  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  control_pipe_if.slave  cp
);
  typedef struct packed {
    logic             r15;
    logic             alusrc;
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic             jump;
    logic [1:0]       aluop;
    logic             halt;
    logic [REG_W-1:0] rd;
  } ctl_t;

  ctl_t dec, ex_q, mem_q, wb_q;
  logic rs_used, rt_used;
  logic halted_q;
  logic hazard;

  always_comb begin
    dec     = '0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    unique case (1'b1)
      cp.id_opcode == 4'b1111: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        dec.r15      = (cp.id_funct == MUL_FN) ||
                       (cp.id_funct == DIV_FN);
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      cp.id_opcode == 4'b1000: begin
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        rs_used      = 1'b1;
      end
      cp.id_opcode == 4'b1001: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      cp.id_opcode inside {[4'b1010:4'b1101]}: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b11;
        rs_used      = 1'b1;
      end
      cp.id_opcode inside {4'b0100, 4'b0101, 4'b0110}: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        rs_used    = 1'b1;
        rt_used    = 1'b1;
      end
      cp.id_opcode == 4'b0001: begin
        dec.jump  = 1'b1;
        dec.aluop = 2'b01;
      end
      cp.id_opcode == 4'b0000: dec.halt = 1'b1;
      default: ;
    endcase
    // rd only matters to stages that write the register file
    dec.rd = dec.regwrite ? cp.id_rd : '0;
  end

  always_comb begin
    hazard = ex_q.memread &&
             ((rs_used && ex_q.rd == cp.id_rs) ||
              (rt_used && ex_q.rd == cp.id_rt));
    cp.stall = HAZ_EN && hazard && cp.id_valid &&
               !cp.ex_branch_taken;
  end

  always_ff @(posedge clk) begin
    if (rst || !cp.id_valid || cp.stall ||
        cp.ex_branch_taken || halted_q)
      ex_q <= '0;
    else
      ex_q <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wb_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      halted_q <= halted_q | wb_q.halt;
    end
  end

  assign cp.ex_alusrc    = ex_q.alusrc;
  assign cp.ex_aluop     = ex_q.aluop;
  assign cp.ex_branch    = ex_q.branch;
  assign cp.ex_jump      = ex_q.jump;
  assign cp.mem_memread  = mem_q.memread;
  assign cp.mem_memwrite = mem_q.memwrite;
  assign cp.wb_memtoreg  = wb_q.memtoreg;
  assign cp.wb_regwrite  = wb_q.regwrite;
  assign cp.wb_r15       = wb_q.r15;
  assign cp.wb_rd        = wb_q.rd;
  assign cp.halted       = halted_q;
endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: hazards, flush,
// MUL/DIV R15 writes, HALT and reset.
module tb_control_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  control_pipe_if #(.REG_W(4), .FUNCT_W(4)) bus ();

  control_pipe dut (
    .clk (clk),
    .rst (rst),
    .cp  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [3:0] op,
                     input logic [3:0] fn, input logic [3:0] rs,
                     input logic [3:0] rt, input logic [3:0] rd);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_funct  = fn;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
    #1;
  endtask

  task automatic idle();
    put(1'b0, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  logic [3:0] fn_tab [3] = '{4'b0100, 4'b0101, 4'b0000};
  logic       r15_tab[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    bus.ex_branch_taken = 1'b0;
    put(1'b1, 4'b1000, 4'h0, 4'h1, 4'h2, 4'h3);
    tick(); tick(); tick();
    chk("rst_ex_aluop", 32'(bus.ex_aluop), 0);
    chk("rst_memread", 32'(bus.mem_memread), 0);
    chk("rst_regwrite", 32'(bus.wb_regwrite), 0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    rst = 1'b0;
    idle();
    tick();

    // load-use: LW r3 then ADD rs=r3
    put(1'b1, 4'b1000, 4'h0, 4'h1, 4'h2, 4'h3);
    tick();
    chk("lw_ex_alusrc", 32'(bus.ex_alusrc), 1);
    chk("lw_ex_aluop", 32'(bus.ex_aluop), 0);
    put(1'b1, 4'b1111, 4'h0, 4'h3, 4'h4, 4'h6);
    chk("lu_stall", 32'(bus.stall), 1);
    tick();
    chk("lu_bubble_aluop", 32'(bus.ex_aluop), 0);
    chk("lu_bubble_alusrc", 32'(bus.ex_alusrc), 0);
    chk("lu_mem_read", 32'(bus.mem_memread), 1);
    chk("lu_stall_once", 32'(bus.stall), 0);
    tick();
    chk("lu_add_aluop", 32'(bus.ex_aluop), 2);
    chk("lu_wb_memtoreg", 32'(bus.wb_memtoreg), 1);
    chk("lu_wb_regwrite", 32'(bus.wb_regwrite), 1);
    chk("lu_wb_rd", 32'(bus.wb_rd), 3);
    idle();
    tick(); tick();
    chk("add_wb_regwrite", 32'(bus.wb_regwrite), 1);
    chk("add_wb_rd", 32'(bus.wb_rd), 6);
    chk("add_wb_memtoreg", 32'(bus.wb_memtoreg), 0);

    // LW r3 then SW rt=r5: no hazard; JMP rs=r3 also no hazard
    put(1'b1, 4'b1000, 4'h0, 4'h1, 4'h2, 4'h3);
    tick();
    put(1'b1, 4'b0001, 4'h0, 4'h3, 4'h3, 4'h0);
    chk("jmp_no_stall", 32'(bus.stall), 0);
    put(1'b1, 4'b1001, 4'h0, 4'h1, 4'h5, 4'h0);
    chk("sw_no_stall", 32'(bus.stall), 0);
    tick();
    chk("sw_mem_read", 32'(bus.mem_memread), 1);
    chk("sw_mem_write0", 32'(bus.mem_memwrite), 0);
    idle();
    tick();
    chk("sw_mem_write1", 32'(bus.mem_memwrite), 1);
    chk("sw_mem_read0", 32'(bus.mem_memread), 0);

    // BEQ in EX, taken, ADD in ID: squashed
    put(1'b1, 4'b0101, 4'h0, 4'h1, 4'h2, 4'h0);
    tick();
    chk("beq_ex_branch", 32'(bus.ex_branch), 1);
    chk("beq_ex_aluop", 32'(bus.ex_aluop), 1);
    put(1'b1, 4'b1111, 4'h0, 4'h3, 4'h4, 4'h6);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall), 0);
    tick();
    bus.ex_branch_taken = 1'b0;
    chk("flush_ex_aluop", 32'(bus.ex_aluop), 0);
    chk("flush_ex_branch", 32'(bus.ex_branch), 0);

    // flush beats a live load-use hazard
    put(1'b1, 4'b1000, 4'h0, 4'h1, 4'h2, 4'h3);
    tick();
    put(1'b1, 4'b1111, 4'h0, 4'h3, 4'h4, 4'h6);
    chk("haz_pre_flush", 32'(bus.stall), 1);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("flush_beats_stall", 32'(bus.stall), 0);
    tick();
    bus.ex_branch_taken = 1'b0;
    chk("flush2_ex_aluop", 32'(bus.ex_aluop), 0);
    chk("flush2_ex_alusrc", 32'(bus.ex_alusrc), 0);

    // immediate ALU and unused opcode
    put(1'b1, 4'b1011, 4'h0, 4'h1, 4'h0, 4'h2);
    tick();
    chk("imm_ex_aluop", 32'(bus.ex_aluop), 3);
    chk("imm_ex_alusrc", 32'(bus.ex_alusrc), 1);
    put(1'b1, 4'b0111, 4'h0, 4'h1, 4'h0, 4'h2);
    tick();
    chk("nop_ex_aluop", 32'(bus.ex_aluop), 0);
    chk("nop_ex_alusrc", 32'(bus.ex_alusrc), 0);
    idle();
    tick(); tick(); tick();

    // MUL / DIV / plain R-type R15 select
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 4'b1111, fn_tab[i], 4'h1, 4'h2, 4'h7);
      tick();
      idle();
      tick(); tick();
      chk("r_wb_regwrite", 32'(bus.wb_regwrite), 1);
      chk("r_wb_r15", 32'(bus.wb_r15), 32'(r15_tab[i]));
      chk("r_wb_rd", 32'(bus.wb_rd), 7);
    end

    // HALT retires, then ID is ignored
    put(1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    idle();
    tick(); tick();
    chk("halt_not_yet", 32'(bus.halted), 0);
    tick();
    chk("halt_set", 32'(bus.halted), 1);
    put(1'b1, 4'b1111, 4'h0, 4'h1, 4'h2, 4'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_ex_aluop", 32'(bus.ex_aluop), 0);
      chk("halt_wb_regwrite", 32'(bus.wb_regwrite), 0);
    end
    chk("halt_sticky", 32'(bus.halted), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_cleared", 32'(bus.halted), 0);
    idle();
    tick();

    // reset discards an in-flight load
    put(1'b1, 4'b1000, 4'h0, 4'h1, 4'h2, 4'h3);
    tick();
    idle();
    tick();
    chk("inflight_memread", 32'(bus.mem_memread), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_memread", 32'(bus.mem_memread), 0);
    chk("rst_mid_regwrite", 32'(bus.wb_regwrite), 0);
    chk("rst_mid_stall", 32'(bus.stall), 0);
    tick();
    chk("rst_mid_wb_after", 32'(bus.wb_regwrite), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
